// File: rtl/lm80c_mem_arbiter.sv
// lm80c_mem_arbiter
// Shares one SDRAM port between the ROM/RAM download path, the memory
// eraser and the CPU. Arbitration happens only on the slot pulse. The
// chosen command is registered, so the SDRAM sees it in the cycle after
// slot. It then stays stable until the next slot.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   slot                 one-cycle arbitration pulse
//   dl_wr/addr/data      download write strobe into the FIFO
//   dl_full              FIFO holds FIFO_DEPTH entries
//   dl_overflow          sticky: a download byte was dropped
//   er_wr/addr/data      eraser write into a one-entry holding register
//   er_ready             eraser write accepted this cycle
//   cpu_addr/din/wr/rd   CPU access, used when nothing else is pending
//   sd_addr/din/we/oe    registered SDRAM command
//   grant                owner: 00 CPU, 01 download, 10 eraser, 11 idle
module lm80c_mem_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 25
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          slot,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_full,
  output logic          dl_overflow,
  input  logic          er_wr,
  input  logic [AW-1:0] er_addr,
  input  logic [7:0]    er_data,
  output logic          er_ready,
  input  logic [15:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_wr,
  input  logic          cpu_rd,
  output logic [AW-1:0] sd_addr,
  output logic [7:0]    sd_din,
  output logic          sd_we,
  output logic          sd_oe,
  output logic [1:0]    grant
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

  // The owner encoding doubles as the state encoding.
  typedef enum logic [1:0] {
    S_CPU  = 2'b00,
    S_DL   = 2'b01,
    S_ER   = 2'b10,
    S_IDLE = 2'b11
  } state_t;

  state_t state, state_nxt;

  // ---------------- download FIFO ----------------
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]    fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty, pop, push;

  assign fifo_empty = (count == '0);
  assign dl_full    = (count == FULL_CNT);
  assign pop        = slot && !fifo_empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push       = dl_wr && (!dl_full || pop);

  // Storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= dl_addr;
      fifo_data[wr_ptr] <= dl_data;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dl_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (dl_wr && !push) dl_overflow <= 1'b1;
    end
  end

  // ---------------- eraser holding register ----------------
  logic          er_valid;
  logic [AW-1:0] er_hold_addr;
  logic [7:0]    er_hold_data;
  logic          er_take;

  // The eraser waits until the download stream has drained.
  assign er_ready = !er_valid && fifo_empty;
  // Uses the registered valid bit. An entry loaded in a slot cycle is
  // therefore not eligible until the following slot.
  assign er_take  = slot && fifo_empty && er_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      er_valid     <= 1'b0;
      er_hold_addr <= '0;
      er_hold_data <= '0;
    end else if (er_take) begin
      er_valid <= 1'b0;
    end else if (er_wr && er_ready) begin
      er_valid     <= 1'b1;
      er_hold_addr <= er_addr;
      er_hold_data <= er_data;
    end
  end

  // ---------------- arbitration FSM ----------------
  logic [AW-1:0] sd_addr_nxt;
  logic [7:0]    sd_din_nxt;
  logic          sd_we_nxt, sd_oe_nxt;

  always_comb begin
    state_nxt   = state;
    sd_addr_nxt = sd_addr;
    sd_din_nxt  = sd_din;
    sd_we_nxt   = sd_we;
    sd_oe_nxt   = sd_oe;
    if (slot) begin
      if (pop) begin
        state_nxt   = S_DL;
        sd_addr_nxt = fifo_addr[rd_ptr];
        sd_din_nxt  = fifo_data[rd_ptr];
        sd_we_nxt   = 1'b1;
        sd_oe_nxt   = 1'b1;
      end else if (er_take) begin
        state_nxt   = S_ER;
        sd_addr_nxt = er_hold_addr;
        sd_din_nxt  = er_hold_data;
        sd_we_nxt   = 1'b1;
        sd_oe_nxt   = 1'b1;
      end else begin
        state_nxt   = S_CPU;
        sd_addr_nxt = {{(AW-16){1'b0}}, cpu_addr};
        sd_din_nxt  = cpu_din;
        sd_we_nxt   = cpu_wr;
        sd_oe_nxt   = cpu_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      sd_addr <= '0;
      sd_din  <= '0;
      sd_we   <= 1'b0;
      sd_oe   <= 1'b0;
    end else begin
      state   <= state_nxt;
      sd_addr <= sd_addr_nxt;
      sd_din  <= sd_din_nxt;
      sd_we   <= sd_we_nxt;
      sd_oe   <= sd_oe_nxt;
    end
  end

  assign grant = state;

endmodule

// File: tb/tb_lm80c_mem_arbiter.sv
module tb_lm80c_mem_arbiter;
  localparam int D  = 4;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset, slot, dl_wr, er_wr, cpu_wr, cpu_rd;
  logic [AW-1:0] dl_addr, er_addr;
  logic [7:0]    dl_data, er_data, cpu_din;
  logic [15:0]   cpu_addr;
  logic          dl_full, dl_overflow, er_ready, sd_we, sd_oe;
  logic [AW-1:0] sd_addr;
  logic [7:0]    sd_din;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  lm80c_mem_arbiter #(.FIFO_DEPTH(D), .AW(AW)) dut (
    .clk(clk), .reset(reset), .slot(slot),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_full(dl_full), .dl_overflow(dl_overflow),
    .er_wr(er_wr), .er_addr(er_addr), .er_data(er_data), .er_ready(er_ready),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe),
    .grant(grant)
  );

  typedef struct packed {
    logic          rst, sl, dw;
    logic [AW-1:0] da;
    logic [7:0]    dd;
    logic          ew;
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    logic [15:0]   ca;
    logic [7:0]    cd;
    logic          cw, cr;
  } vin_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          we, oe;
    logic [1:0]    g;
    logic          full, ovf, rdy;
  } vexp_t;

  typedef struct packed {
    vin_t  i;
    vexp_t e;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // The FIFO is a plain queue and the eraser is a flag plus a value.
  // The command changes only on slot.
  ent_t          q[$];
  bit            m_er, m_ovf;
  ent_t          m_erv;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_din;
  logic          m_we, m_oe;
  logic [1:0]    m_g;

  task automatic model_step(input vin_t v);
    int n;
    bit pop, ew, er_pre;
    if (v.rst) begin
      q.delete();
      m_er = 0; m_ovf = 0;
      m_addr = '0; m_din = '0; m_we = 0; m_oe = 0; m_g = 2'b11;
      return;
    end
    n = q.size();
    er_pre = m_er;
    pop = v.sl && n > 0;
    ew  = v.sl && n == 0 && er_pre;
    if (v.sl) begin
      if (pop) begin
        m_addr = q[0].a; m_din = q[0].d; m_we = 1; m_oe = 1; m_g = 2'b01;
      end else if (ew) begin
        m_addr = m_erv.a; m_din = m_erv.d; m_we = 1; m_oe = 1; m_g = 2'b10;
        m_er = 0;
      end else begin
        m_addr = AW'(v.ca); m_din = v.cd; m_we = v.cw; m_oe = v.cr; m_g = 2'b00;
      end
    end
    if (v.ew && !er_pre && n == 0) begin
      m_er = 1; m_erv = '{a: v.ea, d: v.ed};
    end
    if (pop) void'(q.pop_front());
    if (v.dw) begin
      if (n < D || pop) q.push_back('{a: v.da, d: v.dd});
      else m_ovf = 1;
    end
  endtask

  function automatic vexp_t model_exp();
    vexp_t e;
    e.addr = m_addr; e.din = m_din; e.we = m_we; e.oe = m_oe; e.g = m_g;
    e.full = (q.size() == D);
    e.ovf  = m_ovf;
    e.rdy  = !m_er && q.size() == 0;
    return e;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vexp_t e);
    chk({tag, ".sd_addr"}, 32'(sd_addr), 32'(e.addr));
    chk({tag, ".sd_din"},  32'(sd_din),  32'(e.din));
    chk({tag, ".sd_we"},   32'(sd_we),   32'(e.we));
    chk({tag, ".sd_oe"},   32'(sd_oe),   32'(e.oe));
    chk({tag, ".grant"},   32'(grant),   32'(e.g));
    chk({tag, ".dl_full"}, 32'(dl_full), 32'(e.full));
    chk({tag, ".dl_ovf"},  32'(dl_overflow), 32'(e.ovf));
    chk({tag, ".er_rdy"},  32'(er_ready), 32'(e.rdy));
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic drive(input vin_t v);
    reset = v.rst; slot = v.sl;
    dl_wr = v.dw; dl_addr = v.da; dl_data = v.dd;
    er_wr = v.ew; er_addr = v.ea; er_data = v.ed;
    cpu_addr = v.ca; cpu_din = v.cd; cpu_wr = v.cw; cpu_rd = v.cr;
    model_step(v);
    @(posedge clk); #1;
  endtask

  function automatic vin_t idle_in();
    vin_t v = '0;
    v.cd = 8'h5A;
    return v;
  endfunction

  task automatic do_rst();
    vin_t v = idle_in(); v.rst = 1; drive(v);
  endtask
  task automatic do_idle();
    drive(idle_in());
  endtask
  task automatic do_dl(input logic [AW-1:0] a, input logic [7:0] d);
    vin_t v = idle_in(); v.dw = 1; v.da = a; v.dd = d; drive(v);
  endtask
  task automatic do_er(input logic [AW-1:0] a, input logic [7:0] d);
    vin_t v = idle_in(); v.ew = 1; v.ea = a; v.ed = d; drive(v);
  endtask
  task automatic do_slot(input logic [15:0] ca, input logic cw, input logic cr);
    vin_t v = idle_in(); v.sl = 1; v.ca = ca; v.cw = cw; v.cr = cr; drive(v);
  endtask

  function automatic vec_t row(
    input logic rst, sl, dw, input logic [AW-1:0] da, input logic [7:0] dd,
    input logic [15:0] ca, input logic cw, cr,
    input logic [AW-1:0] ea, input logic [7:0] ed, input logic ewe, eoe,
    input logic [1:0] eg, input logic ef, eo, er);
    vec_t r;
    r.i = idle_in();
    r.i.rst = rst; r.i.sl = sl; r.i.dw = dw; r.i.da = da; r.i.dd = dd;
    r.i.ca = ca; r.i.cw = cw; r.i.cr = cr;
    r.e.addr = ea; r.e.din = ed; r.e.we = ewe; r.e.oe = eoe; r.e.g = eg;
    r.e.full = ef; r.e.ovf = eo; r.e.rdy = er;
    return r;
  endfunction

  vec_t tbl [20];

  initial begin
    // rst sl dw da dd | ca cw cr | addr din we oe g full ovf rdy
    tbl[0]  = row(1,0,0,0,0,     16'h0000,0,0, 0,        8'h00,0,0,2'b11,0,0,1);
    tbl[1]  = row(0,1,0,0,0,     16'h8241,0,1, 25'h8241, 8'h5A,0,1,2'b00,0,0,1);
    tbl[2]  = row(0,0,0,0,0,     16'h0000,0,0, 25'h8241, 8'h5A,0,1,2'b00,0,0,1);
    tbl[3]  = row(0,0,1,0,8'hAA, 16'h0000,0,0, 25'h8241, 8'h5A,0,1,2'b00,0,0,0);
    tbl[4]  = row(0,0,1,1,8'hBB, 16'h0000,0,0, 25'h8241, 8'h5A,0,1,2'b00,0,0,0);
    tbl[5]  = row(0,0,1,2,8'hCC, 16'h0000,0,0, 25'h8241, 8'h5A,0,1,2'b00,0,0,0);
    tbl[6]  = row(0,1,0,0,0,     16'h0000,0,0, 25'h0,    8'hAA,1,1,2'b01,0,0,0);
    tbl[7]  = row(0,1,0,0,0,     16'h0000,0,0, 25'h1,    8'hBB,1,1,2'b01,0,0,0);
    tbl[8]  = row(0,1,0,0,0,     16'h0000,0,0, 25'h2,    8'hCC,1,1,2'b01,0,0,1);
    tbl[9]  = row(0,1,0,0,0,     16'h1234,1,0, 25'h1234, 8'h5A,1,0,2'b00,0,0,1);
    tbl[10] = row(0,0,1,25'h10,8'h10, 16'h0,0,0, 25'h1234, 8'h5A,1,0,2'b00,0,0,0);
    tbl[11] = row(0,0,1,25'h11,8'h11, 16'h0,0,0, 25'h1234, 8'h5A,1,0,2'b00,0,0,0);
    tbl[12] = row(0,0,1,25'h12,8'h12, 16'h0,0,0, 25'h1234, 8'h5A,1,0,2'b00,0,0,0);
    tbl[13] = row(0,0,1,25'h13,8'h13, 16'h0,0,0, 25'h1234, 8'h5A,1,0,2'b00,1,0,0);
    tbl[14] = row(0,0,1,25'h14,8'h14, 16'h0,0,0, 25'h1234, 8'h5A,1,0,2'b00,1,1,0);
    tbl[15] = row(0,1,0,0,0,     16'h0000,0,0, 25'h10,   8'h10,1,1,2'b01,0,1,0);
    tbl[16] = row(0,1,0,0,0,     16'h0000,0,0, 25'h11,   8'h11,1,1,2'b01,0,1,0);
    tbl[17] = row(0,1,0,0,0,     16'h0000,0,0, 25'h12,   8'h12,1,1,2'b01,0,1,0);
    tbl[18] = row(0,1,0,0,0,     16'h0000,0,0, 25'h13,   8'h13,1,1,2'b01,0,1,1);
    tbl[19] = row(0,1,0,0,0,     16'h0000,0,0, 25'h0,    8'h5A,0,0,2'b00,0,1,1);

    drive(idle_in());
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].i);
      check_all($sformatf("tbl%0d", i), tbl[i].e);
    end

    // Full FIFO, push coincident with a pop.
    do_rst();
    for (int k = 0; k < 4; k++) do_dl(AW'(32'h20 + k), 8'(8'h20 + k));
    chk("full4.dl_full", 32'(dl_full), 1);
    begin
      vin_t v = idle_in();
      v.sl = 1; v.dw = 1; v.da = 25'h30; v.dd = 8'h30;
      drive(v);
    end
    chk("pushpop.sd_addr", 32'(sd_addr), 32'h20);
    chk("pushpop.grant",   32'(grant), 1);
    chk("pushpop.dl_full", 32'(dl_full), 1);
    chk("pushpop.dl_ovf",  32'(dl_overflow), 0);
    do_slot(16'h0, 0, 0); chk("drain1.sd_addr", 32'(sd_addr), 32'h21);
    do_slot(16'h0, 0, 0); chk("drain2.sd_addr", 32'(sd_addr), 32'h22);
    do_slot(16'h0, 0, 0); chk("drain3.sd_addr", 32'(sd_addr), 32'h23);
    do_slot(16'h0, 0, 0); chk("drain4.sd_addr", 32'(sd_addr), 32'h30);
    chk("drain4.sd_din", 32'(sd_din), 32'h30);
    chk("drain4.er_rdy", 32'(er_ready), 1);

    // The eraser yields to a download that arrives after it.
    do_rst();
    do_er(25'h100, 8'h00);
    chk("er_load.er_rdy", 32'(er_ready), 0);
    do_dl(25'h5, 8'h77);
    chk("er_dl.er_rdy", 32'(er_ready), 0);
    do_slot(16'h0, 0, 1);
    chk("er_s1.grant",   32'(grant), 1);
    chk("er_s1.sd_addr", 32'(sd_addr), 32'h5);
    chk("er_s1.er_rdy",  32'(er_ready), 0);
    do_slot(16'h0, 0, 1);
    chk("er_s2.grant",   32'(grant), 2);
    chk("er_s2.sd_addr", 32'(sd_addr), 32'h100);
    chk("er_s2.sd_din",  32'(sd_din), 0);
    chk("er_s2.sd_we",   32'(sd_we), 1);
    chk("er_s2.er_rdy",  32'(er_ready), 1);

    // An eraser write in a slot cycle waits for the next slot.
    do_rst();
    begin
      vin_t v = idle_in();
      v.sl = 1; v.ew = 1; v.ea = 25'h1ABCDE; v.ed = 8'h3C; v.ca = 16'h0042; v.cr = 1;
      drive(v);
    end
    chk("er_same.grant",   32'(grant), 0);
    chk("er_same.sd_addr", 32'(sd_addr), 32'h42);
    do_idle();
    chk("er_hold.grant",   32'(grant), 0);
    do_slot(16'h0, 0, 0);
    chk("er_next.grant",   32'(grant), 2);
    chk("er_next.sd_addr", 32'(sd_addr), 32'h1ABCDE);

    // Reset discards queued downloads.
    do_rst();
    do_dl(25'h7, 8'h11);
    do_dl(25'h8, 8'h22);
    do_rst();
    chk("rst2.grant",   32'(grant), 3);
    chk("rst2.dl_full", 32'(dl_full), 0);
    chk("rst2.er_rdy",  32'(er_ready), 1);
    do_slot(16'h4444, 0, 1);
    chk("rst2_s.grant",   32'(grant), 0);
    chk("rst2_s.sd_addr", 32'(sd_addr), 32'h4444);
    chk("rst2_s.sd_we",   32'(sd_we), 0);
    do_slot(16'h4445, 0, 1);
    chk("rst2_s2.grant",  32'(grant), 0);

    // Randomized traffic against the model.
    do_rst();
    for (int c = 0; c < 3000; c++) begin
      vin_t v = idle_in();
      v.rst = ($urandom_range(0, 299) == 0);
      v.sl  = ($urandom_range(0, 2) == 0);
      v.dw  = ($urandom_range(0, 2) == 0);
      v.da  = AW'($urandom);
      v.dd  = 8'($urandom);
      v.ew  = ($urandom_range(0, 3) == 0);
      v.ea  = AW'($urandom);
      v.ed  = 8'($urandom);
      v.ca  = 16'($urandom);
      v.cd  = 8'($urandom);
      v.cw  = 1'($urandom);
      v.cr  = 1'($urandom);
      drive(v);
      check_all($sformatf("rnd%0d", c), model_exp());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lm80c_mem_arbiter.md
LM80C_MEM_ARBITER -- requirements
Module: lm80c_mem_arbiter

Interface
REQ-001 Parameters: FIFO_DEPTH, default 4, download FIFO entries (power of two, 2..16); AW, default 25, SDRAM byte address width.
REQ-002 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sys_clock domain; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 slot  input  1  one-cycle pulse; SDRAM samples the command driven in the cycle after slot.
REQ-006 dl_wr  input  1  one-cycle download write strobe.
REQ-007 dl_addr  input  AW  download byte address.
REQ-008 dl_data  input  8  download byte.
REQ-009 dl_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 dl_overflow  output  1  sticky flag: a download write was dropped.
REQ-011 er_wr  input  1  eraser write strobe.
REQ-012 er_addr  input  AW  eraser address.
REQ-013 er_data  input  8  eraser byte.
REQ-014 er_ready  output  1  eraser write will be accepted this cycle.
REQ-015 cpu_addr  input  16  CPU address.
REQ-016 cpu_din  input  8  CPU write data.
REQ-017 cpu_wr  input  1  CPU write level.
REQ-018 cpu_rd  input  1  CPU read level.
REQ-019 sd_addr  output  AW  registered SDRAM address.
REQ-020 sd_din  output  8  registered SDRAM write data.
REQ-021 sd_we  output  1  registered SDRAM write enable.
REQ-022 sd_oe  output  1  registered SDRAM output enable.
REQ-023 grant  output  2  current owner: 00 CPU, 01 download, 10 eraser, 11 idle.

Function
REQ-024 Download FIFO: push on dl_wr when count < FIFO_DEPTH, or when count = FIFO_DEPTH and a pop occurs in the same cycle.
REQ-025 dl_wr while full with no same-cycle pop drops the byte, sets dl_overflow, and leaves the FIFO unchanged.
REQ-026 dl_full is combinational from the registered count (count == FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
REQ-027 Eraser holding register: one entry.
REQ-028 er_ready = holding register empty AND FIFO empty.
REQ-029 er_wr with er_ready loads the holding register; er_wr without er_ready is ignored, and the eraser holds its request.
REQ-030 Arbitration occurs only in a slot cycle, fixed priority: FIFO non-empty > eraser pending > CPU.
REQ-031 Download win: pop FIFO head; drive sd_addr = head address, sd_din = head data, sd_we = 1, sd_oe = 1; grant = 01.
REQ-032 Eraser win: drive the holding-register contents with sd_we = 1, sd_oe = 1; clear the holding register; grant = 10.
REQ-033 CPU win: sd_addr = {(AW-16) zeros, cpu_addr}, sd_din = cpu_din, sd_we = cpu_wr, sd_oe = cpu_rd; grant = 00.
REQ-034 State machine IDLE/CPU/DL/ER is encoded by grant.
REQ-035 IDLE is entered only by reset and left at the first slot.
REQ-036 All sd_* outputs and grant update only in the cycle after slot and hold stable between slots (one-cycle latency from slot).
REQ-037 A push and a pop in the same cycle leave count unchanged, and the popped entry is the pre-push head.
REQ-038 er_wr and a slot in the same cycle: the new entry is not eligible until the next slot.
REQ-039 A slot while in IDLE with no pending requests selects CPU.

Reset
REQ-040 On reset: FIFO count and pointers = 0, eraser holding register empty, dl_overflow = 0, dl_full = 0, er_ready = 1.
REQ-041 On reset: sd_addr = 0, sd_din = 0, sd_we = 0, sd_oe = 0, grant = 11.
REQ-042 Reset mid-operation discards all queued and held writes, with no SDRAM command issued for them.

Verification
REQ-043 Reset, then slot with cpu_addr=16'h8241, cpu_rd=1 -> next cycle sd_addr=25'h0008241, sd_oe=1, sd_we=0, grant=00.
REQ-044 Three dl_wr (addr 0,1,2; data AA,BB,CC) then three slots -> three writes in order, grant=01 each; the fourth slot gives grant=00.
REQ-045 Five dl_wr with no slot (FIFO_DEPTH=4) -> dl_full=1 after the fourth, dl_overflow=1 after the fifth, and only 4 writes issued later.
REQ-046 FIFO full, dl_wr coincident with slot -> push accepted, count stays 4, dl_overflow stays 0.
REQ-047 er_wr (addr 25'h100, data 00) with the FIFO empty, then one dl_wr, then slot -> the download issues first, er_ready=0 meanwhile; the next slot issues the eraser write, grant=10.
REQ-048 Reset asserted with 2 FIFO entries pending -> the following slot issues a CPU access, grant=00, with no download write.
